// File: rtl/hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_unit_pkg
// Shared pipeline definitions used by the ID/EX stages and the hazard unit:
//   - fwd_sel_e   : operand-select encoding (regfile / EX / MA / WB)
//   - stage_rec_t : tracking record held per pipeline stage
//   - fwd_pick()  : youngest-producer priority select
// No ports (package).
// -----------------------------------------------------------------------------
package hazard_unit_pkg;

    // Destination field width inside the stage record; register-address
    // widths up to this value are zero-extended into it.
    localparam int STAGE_DST_W = 8;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_EX = 2'd1,
        FWD_MA = 2'd2,
        FWD_WB = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic                   valid;
        logic [STAGE_DST_W-1:0] dst;
        logic                   wr;
        logic                   load;
    } stage_rec_t;

    localparam stage_rec_t STAGE_BUBBLE = '{valid: 1'b0, dst: '0, wr: 1'b0, load: 1'b0};

    // Youngest matching producer wins: EX, then MA, then WB.
    function automatic fwd_sel_e fwd_pick(input logic m_ex, input logic m_ma, input logic m_wb);
        fwd_sel_e sel;
        if (m_ex) begin
            sel = FWD_EX;
        end else if (m_ma) begin
            sel = FWD_MA;
        end else if (m_wb) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_unit_if
// Decode-stage <-> hazard-unit bundle.
//   master : decode side, drives the ID instruction fields and flush,
//            receives stall / fwd_sel / stall_cnt.
//   slave  : hazard unit, the reverse.
// Signals:
//   id_valid, id_src[NUM_SRC*ADDR_W], id_src_used[NUM_SRC], id_dst[ADDR_W],
//   id_reg_write, id_is_load, flush, stall, fwd_sel[NUM_SRC*2], stall_cnt[CNT_W]
// -----------------------------------------------------------------------------
interface hazard_unit_if #(
    parameter int ADDR_W  = 2,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);
    logic                      id_valid;
    logic [NUM_SRC*ADDR_W-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [ADDR_W-1:0]         id_dst;
    logic                      id_reg_write;
    logic                      id_is_load;
    logic                      flush;
    logic                      stall;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic [CNT_W-1:0]          stall_cnt;

    modport master (
        output id_valid, id_src, id_src_used, id_dst, id_reg_write, id_is_load, flush,
        input  stall, fwd_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_src, id_src_used, id_dst, id_reg_write, id_is_load, flush,
        output stall, fwd_sel, stall_cnt
    );
endinterface

// File: rtl/hazard_unit_cmp.sv
// -----------------------------------------------------------------------------
// hazard_cmp
// Compares one decode source operand against one pipeline stage record.
// Ports:
//   stage    in  stage_rec_t    tracked stage contents
//   src      in  ADDR_W         source register address
//   src_used in  1              source is actually read
//   id_valid in  1              decode holds a real instruction
//   match    out 1              stage produces this source's value
// -----------------------------------------------------------------------------
module hazard_cmp
    import hazard_unit_pkg::*;
#(
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 1
) (
    input  stage_rec_t        stage,
    input  logic [ADDR_W-1:0] src,
    input  logic              src_used,
    input  logic              id_valid,
    output logic              match
);
    logic src_is_zero_s;
    // The load flag is resolved by the caller for the EX stage only.
    logic unused_load_s;

    assign unused_load_s = stage.load;
    assign src_is_zero_s = (ZERO_REG != 0) && (src == '0);
    assign match = stage.valid && stage.wr && id_valid && src_used && !src_is_zero_s
                   && (stage.dst == STAGE_DST_W'(src));
endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Tracks the destinations of instructions in EX/MA/WB and, for the
// instruction in decode, produces a stall request and per-source operand
// forwarding selects. Counts stall cycles with a saturating counter.
// Ports:
//   clk   in   clock, all state on rising edge
//   rst   in   asynchronous active-low reset
//   bus   slave modport of hazard_unit_if (ID fields, flush, stall,
//         fwd_sel, stall_cnt)
// stall and fwd_sel are combinational from the stage registers and ID inputs;
// stall_cnt is registered. ADDR_W must not exceed STAGE_DST_W.
// -----------------------------------------------------------------------------
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int ADDR_W   = 2,
    parameter int NUM_SRC  = 2,
    parameter int FWD_EN   = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave bus
);
    stage_rec_t           ex_r;
    stage_rec_t           ma_r;
    stage_rec_t           wb_r;
    logic [CNT_W-1:0]     cnt_r;

    logic [NUM_SRC-1:0]   m_ex_s;
    logic [NUM_SRC-1:0]   m_ma_s;
    logic [NUM_SRC-1:0]   m_wb_s;
    logic                 stall_s;
    logic [NUM_SRC*2-1:0] fwd_s;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        hazard_cmp #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_cmp_ex (
            .stage    (ex_r),
            .src      (bus.id_src[k*ADDR_W +: ADDR_W]),
            .src_used (bus.id_src_used[k]),
            .id_valid (bus.id_valid),
            .match    (m_ex_s[k])
        );
        hazard_cmp #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_cmp_ma (
            .stage    (ma_r),
            .src      (bus.id_src[k*ADDR_W +: ADDR_W]),
            .src_used (bus.id_src_used[k]),
            .id_valid (bus.id_valid),
            .match    (m_ma_s[k])
        );
        hazard_cmp #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_cmp_wb (
            .stage    (wb_r),
            .src      (bus.id_src[k*ADDR_W +: ADDR_W]),
            .src_used (bus.id_src_used[k]),
            .id_valid (bus.id_valid),
            .match    (m_wb_s[k])
        );
    end

    // Stall request: flush wins; with forwarding only a load in EX blocks,
    // without forwarding any EX/MA producer blocks (WB is write-before-read).
    always_comb begin
        stall_s = 1'b0;
        if (bus.flush) begin
            stall_s = 1'b0;
        end else if (FWD_EN != 0) begin
            stall_s = (|m_ex_s) && ex_r.load;
        end else begin
            stall_s = (|m_ex_s) || (|m_ma_s);
        end
    end

    // Per-source operand select, resolved independently for each source.
    always_comb begin
        fwd_s = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if ((FWD_EN != 0) && !stall_s) begin
                fwd_s[k*2 +: 2] = fwd_pick(m_ex_s[k], m_ma_s[k], m_wb_s[k]);
            end else begin
                fwd_s[k*2 +: 2] = FWD_RF;
            end
        end
    end

    // Stage tracking shift (EX takes a bubble on stall/flush) and saturating stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_r  <= STAGE_BUBBLE;
            ma_r  <= STAGE_BUBBLE;
            wb_r  <= STAGE_BUBBLE;
            cnt_r <= '0;
        end else begin
            wb_r <= ma_r;
            ma_r <= ex_r;
            if (stall_s || bus.flush) begin
                ex_r <= STAGE_BUBBLE;
            end else begin
                ex_r <= '{valid: bus.id_valid,
                          dst:   STAGE_DST_W'(bus.id_dst),
                          wr:    bus.id_reg_write,
                          load:  bus.id_is_load};
            end
            if (stall_s && (cnt_r != '1)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.stall     = stall_s;
    assign bus.fwd_sel   = fwd_s;
    assign bus.stall_cnt = cnt_r;
endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Four hazard_unit instances share the same ID stimulus:
//   d0 default, d1 ZERO_REG=0, d2 FWD_EN=0, d3 CNT_W=4.
// Stimulus pushes expected {stall, fwd_sel, stall_cnt} per instance into a
// queue tagged with the cycle number; a monitor pops and compares on the
// falling edge (or on an explicit mid-cycle probe for the async-reset case).
// -----------------------------------------------------------------------------
module tb_hazard_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0;
    logic [3:0] id_src = 4'd0;
    logic [1:0] id_src_used = 2'd0;
    logic [1:0] id_dst = 2'd0;
    logic       id_reg_write = 1'b0;
    logic       id_is_load = 1'b0;
    logic       flush = 1'b0;

    int cyc_cnt  = 0;
    int checks   = 0;
    int failures = 0;
    event probe_ev;

    typedef struct {
        int          cyc;
        int          dut;
        string       name;
        logic        stall;
        logic [3:0]  fwd;
        logic [15:0] cnt;
    } exp_t;
    exp_t exp_q[$];

    hazard_unit_if #(.ADDR_W(2), .NUM_SRC(2), .CNT_W(16)) if0 ();
    hazard_unit_if #(.ADDR_W(2), .NUM_SRC(2), .CNT_W(16)) if1 ();
    hazard_unit_if #(.ADDR_W(2), .NUM_SRC(2), .CNT_W(16)) if2 ();
    hazard_unit_if #(.ADDR_W(2), .NUM_SRC(2), .CNT_W(4))  if3 ();

    assign if0.id_valid = id_valid;  assign if0.id_src = id_src;  assign if0.id_src_used = id_src_used;
    assign if0.id_dst = id_dst;  assign if0.id_reg_write = id_reg_write;  assign if0.id_is_load = id_is_load;
    assign if0.flush = flush;
    assign if1.id_valid = id_valid;  assign if1.id_src = id_src;  assign if1.id_src_used = id_src_used;
    assign if1.id_dst = id_dst;  assign if1.id_reg_write = id_reg_write;  assign if1.id_is_load = id_is_load;
    assign if1.flush = flush;
    assign if2.id_valid = id_valid;  assign if2.id_src = id_src;  assign if2.id_src_used = id_src_used;
    assign if2.id_dst = id_dst;  assign if2.id_reg_write = id_reg_write;  assign if2.id_is_load = id_is_load;
    assign if2.flush = flush;
    assign if3.id_valid = id_valid;  assign if3.id_src = id_src;  assign if3.id_src_used = id_src_used;
    assign if3.id_dst = id_dst;  assign if3.id_reg_write = id_reg_write;  assign if3.id_is_load = id_is_load;
    assign if3.flush = flush;

    hazard_unit u_d0 (.clk(clk), .rst(rst), .bus(if0));
    hazard_unit #(.ZERO_REG(0)) u_d1 (.clk(clk), .rst(rst), .bus(if1));
    hazard_unit #(.FWD_EN(0))   u_d2 (.clk(clk), .rst(rst), .bus(if2));
    hazard_unit #(.CNT_W(4))    u_d3 (.clk(clk), .rst(rst), .bus(if3));

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [1:0] s1, input logic [1:0] s0,
                          input logic [1:0] used, input logic [1:0] dst,
                          input logic wr, input logic ld);
        id_valid     = v;
        id_src       = {s1, s0};
        id_src_used  = used;
        id_dst       = dst;
        id_reg_write = wr;
        id_is_load   = ld;
    endtask

    task automatic push_exp(input int dut, input string name, input logic st,
                            input logic [3:0] fw, input logic [15:0] cn);
        exp_t e;
        e.cyc = cyc_cnt; e.dut = dut; e.name = name;
        e.stall = st; e.fwd = fw; e.cnt = cn;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        set_id(1'b0, 2'd0, 2'd0, 2'b00, 2'd0, 1'b0, 1'b0);
        flush = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    // Monitor: compare every expectation due by the current cycle.
    initial begin
        exp_t        e;
        logic        st;
        logic [3:0]  fw;
        logic [15:0] cn;
        forever begin
            @(negedge clk or probe_ev);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
                e = exp_q.pop_front();
                case (e.dut)
                    0:       begin st = if0.stall; fw = if0.fwd_sel; cn = if0.stall_cnt; end
                    1:       begin st = if1.stall; fw = if1.fwd_sel; cn = if1.stall_cnt; end
                    2:       begin st = if2.stall; fw = if2.fwd_sel; cn = if2.stall_cnt; end
                    default: begin st = if3.stall; fw = if3.fwd_sel; cn = {12'd0, if3.stall_cnt}; end
                endcase
                checks++;
                if (e.cyc != cyc_cnt || st !== e.stall || fw !== e.fwd || cn !== e.cnt) begin
                    failures++;
                    $display("FAIL %s d%0d: got stall=%b fwd=%h cnt=%0d, want stall=%b fwd=%h cnt=%0d (cyc %0d/%0d)",
                             e.name, e.dut, st, fw, cn, e.stall, e.fwd, e.cnt, e.cyc, cyc_cnt);
                end
            end
        end
    end

    initial begin
        // Reset with a busy ID stage: nothing tracked, so outputs stay quiet.
        rst = 1'b0;
        set_id(1'b1, 2'd1, 2'd2, 2'b11, 2'd1, 1'b1, 1'b1);
        step();
        push_exp(0, "reset_d0", 1'b0, 4'h0, 16'd0);
        push_exp(3, "reset_d3", 1'b0, 4'h0, 16'd0);
        step();

        // ALU forward: EX then MA.
        do_reset();
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd1, 1'b1, 1'b0); step();
        set_id(1'b1, 2'd0, 2'd1, 2'b01, 2'd3, 1'b1, 1'b0);
        push_exp(0, "s1_fwd_ex", 1'b0, 4'h1, 16'd0); step();
        push_exp(0, "s1_fwd_ma", 1'b0, 4'h2, 16'd0); step();

        // Load-use: one stall cycle, then MA forward.
        do_reset();
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd2, 1'b1, 1'b1); step();
        set_id(1'b1, 2'd2, 2'd0, 2'b10, 2'd3, 1'b1, 1'b0);
        push_exp(0, "s2_stall", 1'b1, 4'h0, 16'd0); step();
        push_exp(0, "s2_fwd_ma", 1'b0, 4'h8, 16'd1); step();
        set_id(1'b0, 2'd0, 2'd0, 2'b00, 2'd0, 1'b0, 1'b0);
        push_exp(0, "s2_cnt_hold", 1'b0, 4'h0, 16'd1); step();

        // Register zero: hardwired on d0, ordinary on d1.
        do_reset();
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd0, 1'b1, 1'b0); step();
        set_id(1'b1, 2'd0, 2'd0, 2'b01, 2'd3, 1'b1, 1'b0);
        push_exp(0, "s3_zero_reg", 1'b0, 4'h0, 16'd0);
        push_exp(1, "s3_no_zero_reg", 1'b0, 4'h1, 16'd0); step();

        // No forwarding: two stall cycles on d2.
        do_reset();
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd3, 1'b1, 1'b0); step();
        set_id(1'b1, 2'd0, 2'd3, 2'b01, 2'd1, 1'b1, 1'b0);
        push_exp(2, "s4_stall1", 1'b1, 4'h0, 16'd0);
        push_exp(0, "s4_fwd_ref", 1'b0, 4'h1, 16'd0); step();
        push_exp(2, "s4_stall2", 1'b1, 4'h0, 16'd1);
        push_exp(0, "s4_fwd_ref_ma", 1'b0, 4'h2, 16'd0); step();
        push_exp(2, "s4_release", 1'b0, 4'h0, 16'd2); step();

        // Two sources resolved independently, including WB.
        do_reset();
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd1, 1'b1, 1'b0); step();
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd2, 1'b1, 1'b0); step();
        set_id(1'b1, 2'd2, 2'd1, 2'b11, 2'd3, 1'b1, 1'b0);
        push_exp(0, "multi_ex_ma", 1'b0, 4'h6, 16'd0);
        push_exp(1, "multi_ex_ma_d1", 1'b0, 4'h6, 16'd0); step();
        push_exp(0, "multi_ma_wb", 1'b0, 4'hB, 16'd0); step();

        // id_valid low masks a would-be load-use.
        do_reset();
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd2, 1'b1, 1'b1); step();
        set_id(1'b0, 2'd2, 2'd0, 2'b10, 2'd0, 1'b0, 1'b0);
        push_exp(0, "id_invalid", 1'b0, 4'h0, 16'd0); step();

        // Flush beats stall; EX must then hold a bubble (B's own dst=2 would show as EX).
        do_reset();
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd2, 1'b1, 1'b1); step();
        set_id(1'b1, 2'd2, 2'd0, 2'b10, 2'd2, 1'b1, 1'b0);
        flush = 1'b1;
        push_exp(0, "s5_flush", 1'b0, 4'h4, 16'd0); step();
        flush = 1'b0;
        push_exp(0, "s5_ex_bubble", 1'b0, 4'h8, 16'd0); step();

        // Asynchronous reset in the middle of a two-cycle stall on d2.
        do_reset();
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd3, 1'b1, 1'b0); step();
        set_id(1'b1, 2'd0, 2'd3, 2'b01, 2'd1, 1'b1, 1'b0);
        push_exp(2, "s5r_stall1", 1'b1, 4'h0, 16'd0); step();
        push_exp(2, "s5r_stall2", 1'b1, 4'h0, 16'd1);
        #6;
        rst = 1'b0;
        #1;
        push_exp(2, "s5r_async_clear", 1'b0, 4'h0, 16'd0);
        -> probe_ev;
        step();
        rst = 1'b1;
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd3, 1'b1, 1'b0); step();
        set_id(1'b1, 2'd0, 2'd3, 2'b01, 2'd1, 1'b1, 1'b0);
        push_exp(2, "s5r_first_capture", 1'b1, 4'h0, 16'd0); step();

        // Saturation: self-dependent load stalls every other cycle, 20 stalls total.
        do_reset();
        set_id(1'b1, 2'd2, 2'd0, 2'b10, 2'd2, 1'b1, 1'b1);
        for (int i = 0; i <= 40; i++) begin
            int         n;
            logic [3:0] f;
            n = i / 2;
            f = (i >= 2 && (i % 2) == 0) ? 4'h8 : 4'h0;
            push_exp(3, "s6_sat", logic'((i % 2) == 1), f, 16'((n > 15) ? 15 : n));
            if (i == 40) push_exp(0, "s6_wide_cnt", 1'b0, 4'h8, 16'd20);
            step();
        end
        set_id(1'b0, 2'd0, 2'd0, 2'b00, 2'd0, 1'b0, 1'b0);
        push_exp(3, "s6_no_wrap", 1'b0, 4'h0, 16'd15);
        step();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL expose parameters, one per line:
- ADDR_W, default 2: register-address width.
- NUM_SRC, default 2: source operands per instruction.
- FWD_EN, default 1: 1 = forward where possible; 0 = stall on every dependency.
- ZERO_REG, default 1: 1 = register 0 is hardwired and never a hazard.
- CNT_W, default 16: stall-counter width.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_src  in  NUM_SRC*ADDR_W  source register addresses; source k occupies bits [k*ADDR_W +: ADDR_W].
- id_src_used  in  NUM_SRC  source k is actually read.
- id_dst  in  ADDR_W  destination register.
- id_reg_write  in  1  instruction writes id_dst.
- id_is_load  in  1  instruction is a memory load.
- flush  in  1  squash the decode instruction and the EX stage.
- stall  out  1  hold the PC and the ID register this cycle.
- fwd_sel  out  NUM_SRC*2  per-source operand select: 0 = regfile, 1 = EX, 2 = MA, 3 = WB.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-003 The block SHALL keep three tracking stages, EX, MA and WB. Each stage holds {valid, dst, wr, load}.

REQ-004 A stage SHALL match source k when all of the following hold: stage valid, wr = 1, dst = src k, id_src_used[k] = 1, id_valid = 1, and not (ZERO_REG = 1 and src k = 0).

REQ-005 With FWD_EN = 1, stall SHALL assert combinationally when any source matches EX and EX.load = 1 (load-use).

REQ-006 With FWD_EN = 0, stall SHALL assert when any source matches EX or MA. WB needs no stall because the regfile is write-before-read.

REQ-007 With FWD_EN = 1, fwd_sel[k] SHALL select the youngest matching stage (priority EX, then MA, then WB) and 0 if no stage matches.

REQ-008 fwd_sel SHALL be 0 for all sources whenever stall = 1, and always when FWD_EN = 0.

REQ-009 At each rising edge, WB SHALL load the contents of MA, and MA SHALL load the contents of EX.

REQ-010 At each rising edge, EX SHALL load {id_valid, id_dst, id_reg_write, id_is_load}, except that EX SHALL load a bubble (valid = 0) when stall = 1 or flush = 1.

REQ-011 flush SHALL take priority over stall. While flush = 1, stall SHALL be 0, stall_cnt SHALL NOT increment, and MA/WB SHALL shift normally.

REQ-012 stall_cnt SHALL increment on each edge where stall = 1 and SHALL saturate at all-ones without wrapping.

REQ-013 When id_valid = 0, stall SHALL be 0 and fwd_sel SHALL be 0 for all sources.

REQ-014 When several sources match different stages in the same cycle, each source's fwd_sel SHALL be resolved independently. A stall caused by any one source SHALL stall the whole instruction.

REQ-015 An instruction whose id_dst equals one of its own sources SHALL NOT match itself; only EX/MA/WB entries are compared.

Reset
REQ-016 While rst = 0, every stage's valid SHALL be 0 and stall_cnt SHALL be 0. As a result stall = 0 and fwd_sel = 0 regardless of the ID inputs.

REQ-017 Reset asserted mid-stall SHALL clear the pipeline tracking immediately (asynchronously). The first edge after rst deasserts SHALL capture the ID instruction normally.

Structure
REQ-018 The fwd_sel encodings (FWD_RF = 0, FWD_EX = 1, FWD_MA = 2, FWD_WB = 3) and the stage-record typedef SHALL live in a shared pipeline package that the ID and EX stages also use.

REQ-019 A sub-module hazard_cmp SHALL compare one source against one stage record, returning the match bit. hazard_unit SHALL instantiate it NUM_SRC x 3 times.

REQ-020 The RTL SHALL contain no latches, and stall/fwd_sel SHALL be purely combinational from the stage registers and the ID inputs.

Verification
REQ-021 Scenario 1 (ALU forward): instruction A {dst = 1, wr = 1, load = 0}, then B {src0 = 1, used = 01} on the next cycle -> in B's ID cycle, stall = 0 and fwd_sel[0] = 1 (EX); one cycle later with B held in ID, fwd_sel[0] = 2.

REQ-022 Scenario 2 (load-use): load {dst = 2}, then B {src1 = 2} -> stall = 1 for exactly one cycle, EX holds a bubble, then fwd_sel[1] = 2 (MA); stall_cnt = 1.

REQ-023 Scenario 3 (ZERO_REG): instruction {dst = 0, wr = 1}, then {src0 = 0} -> stall = 0, fwd_sel = 0. With ZERO_REG = 0 the same sequence gives fwd_sel[0] = 1.

REQ-024 Scenario 4 (FWD_EN = 0): instruction A {dst = 3}, then B {src0 = 3} -> stall = 1 for two cycles, B released in the third cycle with fwd_sel = 0; stall_cnt = 2.

REQ-025 Scenario 5 (flush over stall): the load-use condition of Scenario 2 with flush = 1 in the same cycle -> stall = 0 and EX captures a bubble. Separately, assert rst = 0 mid-stall -> stall drops without waiting for a clock edge and stall_cnt = 0.

REQ-026 Scenario 6 (saturation): CNT_W = 4, hold a load-use hazard for 20 cycles -> stall_cnt reads 15 and does not wrap.
